conv_bias_ctrl: RTL

CONV_BIAS_CTRL -- requirements
Module: conv_bias_ctrl

---
 rtl/conv_bias_ctrl_pkg.sv | 19 +
 rtl/bias_valid_delay.sv | 28 ++
 rtl/conv_bias_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/conv_bias_ctrl_pkg.sv
// conv_bias_ctrl_pkg: shared constants and FSM encoding for the bias controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: PICTURE_NUM, GROUP_SHIFT (channels per group = 1 << GROUP_SHIFT), state_t.
package conv_bias_ctrl_pkg;

  localparam int PICTURE_NUM = 1;
  localparam int GROUP_SHIFT = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FIFO = 3'd1,
    READ      = 3'd2,
    NEXT_GRP  = 3'd3,
    FLUSH     = 3'd4,
    DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/bias_valid_delay.sv
// bias_valid_delay: fixed-depth shift register that turns the FIFO read strobe into the
//   adder output-valid.
// Latency: dout = din delayed by exactly DEPTH cycles.
// Backpressure: none; it shifts every cycle regardless of downstream readiness.
// Ports: clk, rst (sync, active-high, clears all stages), din (read strobe), dout (valid).
module bias_valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage;

  // Shift-and-insert form keeps DEPTH=1 legal without a special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= (stage << 1) | DEPTH'(din);
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_bias_ctrl.sv
// conv_bias_ctrl: walks rows x groups of one conv layer, reading one burst of bias words per
//   (row, group) from the bias FIFO and tracking the adder output-valid.
// Latency: M_Valid = rd_en_fifo delayed 1+ADD_LATENCY cycles; Done follows the last M_Valid.
// Backpressure: with CONV_BIAS_BACKPRESSURE_EN defined, M_Ready=0 stalls READ (no read, no
//   counter advance) while the valid pipeline keeps draining; without it M_Ready is ignored.
// Ports: clk, rst (sync, active-high); Start pulse latches Channel_Out_Num_REG,
//   Row_Num_Out_REG, S_Count_Fifo; fifo_ready, M_Ready in; rd_en_fifo, bias_addr (group index),
//   M_Valid, Next_Reg, Busy, Done out.
module conv_bias_ctrl
  import conv_bias_ctrl_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int ADD_LATENCY           = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Start,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    S_Count_Fifo,
  input  logic                             fifo_ready,
  input  logic                             M_Ready,
  output logic                             rd_en_fifo,
  output logic [WIDTH_CHANNEL_NUM_REG-1:0] bias_addr,
  output logic                             M_Valid,
  output logic                             Next_Reg,
  output logic                             Busy,
  output logic                             Done
);

  localparam int FW  = WIDTH_FEATURE_SIZE;
  localparam int CW  = WIDTH_CHANNEL_NUM_REG;
  localparam int FLW = $clog2(ADD_LATENCY + 2);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   ch_reg;
  logic [CW-1:0]   grp_cnt;
  logic [CW-1:0]   grp_num;
  logic [FW-1:0]   row_reg;
  logic [FW-1:0]   cnt_reg;
  logic [FW-1:0]   row_cnt;
  logic [FW-1:0]   word_cnt;
  logic [FLW-1:0]  flush_cnt;
  logic            rd_ok;
  logic            last_word;
  logic            last_grp;
  logic            last_row;
  logic            empty_layer;

  // Fewer channels than one full group still needs one bias group.
  assign grp_num     = (ch_reg < CW'(CHANNEL_OUT_NUM)) ? CW'(1) : (ch_reg >> GROUP_SHIFT);
  assign last_word   = (word_cnt == cnt_reg - FW'(1));
  assign last_grp    = (grp_cnt == grp_num - CW'(1));
  assign last_row    = (row_cnt == row_reg - FW'(1));
  assign empty_layer = (row_reg == '0) || (cnt_reg == '0);

`ifdef CONV_BIAS_BACKPRESSURE_EN
  assign rd_ok = (state == READ) && M_Ready;
`else
  logic unused_m_ready;
  assign unused_m_ready = M_Ready;
  assign rd_ok = (state == READ);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (Start) state_nxt = WAIT_FIFO;
      WAIT_FIFO: begin
        if (empty_layer)     state_nxt = DONE;
        else if (fifo_ready) state_nxt = READ;
      end
      READ:      if (rd_ok && last_word) state_nxt = NEXT_GRP;
      NEXT_GRP:  state_nxt = (last_grp && last_row) ? FLUSH : WAIT_FIFO;
      FLUSH:     if (flush_cnt == FLW'(ADD_LATENCY)) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rd_en_fifo = rd_ok;
    Busy       = (state != IDLE);
    Done       = (state == DONE);
    Next_Reg   = (state == DONE);
  end

  // Layer configuration and counters. The group counter doubles as the registered bias
  // address; it only moves in NEXT_GRP, so the burst's last word (whose bias is fetched
  // one cycle after its read) still sees its own group.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_reg    <= '0;
      row_reg   <= '0;
      cnt_reg   <= '0;
      grp_cnt   <= '0;
      row_cnt   <= '0;
      word_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            ch_reg    <= Channel_Out_Num_REG;
            row_reg   <= Row_Num_Out_REG;
            cnt_reg   <= S_Count_Fifo;
            grp_cnt   <= '0;
            row_cnt   <= '0;
            word_cnt  <= '0;
            flush_cnt <= '0;
          end
        end
        READ: begin
          if (rd_ok) word_cnt <= last_word ? '0 : word_cnt + FW'(1);
        end
        NEXT_GRP: begin
          if (last_grp) begin
            grp_cnt <= '0;
            if (!last_row) row_cnt <= row_cnt + FW'(1);
          end else begin
            grp_cnt <= grp_cnt + CW'(1);
          end
        end
        FLUSH: flush_cnt <= flush_cnt + FLW'(1);
        default: ;
      endcase
    end
  end

  assign bias_addr = grp_cnt;

  bias_valid_delay #(
    .DEPTH (1 + ADD_LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en_fifo),
    .dout (M_Valid)
  );

endmodule
